alu_flag_unit: RTL

Condition-flag register and branch-condition evaluator that consumes the ALU's per-cycle status outputs (negative, zero, overflow, carry). Latches the flags on flag-setting instructions, keeps a sticky overflow indicator and an optional saturating overflow-event counter, and answers registered branch-condition queries for the control unit. Sits between the ALU flag outputs and the datapath control / branch logic.

---
 rtl/alu_flag_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_flag_unit.sv
// Condition-flag register with forwarding branch-condition evaluator, sticky overflow
// and optional saturating overflow-event counter (enabled by OVF_COUNTER_EN).
module alu_flag_unit #(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               alu_n,
   input  logic               alu_z,
   input  logic               alu_v,
   input  logic               alu_c,
   input  logic               set_flags,
   input  logic               clr_sticky,
   input  logic               cond_valid,
   input  logic [2:0]         cond,
   output logic [3:0]         flags,
   output logic               ovf_sticky,
   output logic [COUNT_W-1:0] ovf_count,
   output logic               res_valid,
   output logic               res_taken
);

   typedef enum logic [2:0] {
      COND_EQ = 3'd0,
      COND_NE = 3'd1,
      COND_LT = 3'd2,
      COND_GE = 3'd3,
      COND_GT = 3'd4,
      COND_LE = 3'd5,
      COND_VS = 3'd6,
      COND_AL = 3'd7
   } cond_e;

   logic [3:0] eff_flags;
   logic       eff_n;
   logic       eff_z;
   logic       eff_v;
   logic       n_xor_v;
   logic       taken_next;
   logic       ovf_event;
   cond_e      cond_code;

   // A flag-setting instruction in the query cycle is forwarded so that
   // compare-and-branch pairs issued together see the fresh flags.
   always_comb begin
      eff_flags = flags;
      if (set_flags) begin
         eff_flags = {alu_n, alu_z, alu_v, alu_c};
      end
   end

   assign eff_n     = eff_flags[3];
   assign eff_z     = eff_flags[2];
   assign eff_v     = eff_flags[1];
   assign n_xor_v   = eff_n ^ eff_v;
   assign cond_code = cond_e'(cond);
   assign ovf_event = set_flags & alu_v;

   always_comb begin
      taken_next = 1'b0;
      case (cond_code)
         COND_EQ: taken_next = eff_z;
         COND_NE: taken_next = ~eff_z;
         COND_LT: taken_next = n_xor_v;
         COND_GE: taken_next = ~n_xor_v;
         COND_GT: taken_next = ~eff_z & ~n_xor_v;
         COND_LE: taken_next = eff_z | n_xor_v;
         COND_VS: taken_next = eff_v;
         COND_AL: taken_next = 1'b1;
         default: taken_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags <= 4'b0000;
      end else if (set_flags) begin
         flags <= {alu_n, alu_z, alu_v, alu_c};
      end
   end

   // Query handshake: cond_valid at cycle t yields res_valid for exactly cycle t+1
   // with res_taken evaluated from the effective flags of cycle t; there is no
   // back-pressure, so a request may be issued every cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_taken <= 1'b0;
      end else begin
         res_valid <= cond_valid;
         res_taken <= cond_valid & taken_next;
      end
   end

   // An overflow event in the clearing cycle wins so it is never lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
      end else if (ovf_event) begin
         ovf_sticky <= 1'b1;
      end else if (clr_sticky) begin
         ovf_sticky <= 1'b0;
      end
   end

`ifdef OVF_COUNTER_EN
   localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
   localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] count_next;

   always_comb begin
      count_next = count_q;
      if (ovf_event) begin
         if (clr_sticky) begin
            count_next = COUNT_ONE;
         end else if (count_q != COUNT_MAX) begin
            count_next = count_q + COUNT_ONE;
         end
      end else if (clr_sticky) begin
         count_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_next;
      end
   end

   assign ovf_count = count_q;
`else
   assign ovf_count = '0;
`endif

endmodule
